// File: rtl/count_uart_tx.sv
// count_uart_tx: sends each accepted byte as an 8N1 UART frame, LSB first (8E1 when COUNT_UART_TX_PARITY_EN is defined).
// Latency: start bit is on tx from the acceptance edge; frame_done comes 10*CLKS_PER_BIT cycles later (11* with parity).
// Backpressure: in_ready is high only in IDLE; upstream holds in_valid/in_data until the byte is taken.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef COUNT_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic          tx_nxt;
    logic          done_nxt;
    logic          baud_last;
`ifdef COUNT_UART_TX_PARITY_EN
    logic          par, par_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            baud_cnt   <= baud_nxt;
            tx         <= tx_nxt;
            frame_done <= done_nxt;
`ifdef COUNT_UART_TX_PARITY_EN
            par        <= par_nxt;
`endif
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);

    // tx is registered, so it is loaded with the level of the state being entered.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        baud_nxt    = baud_cnt;
        tx_nxt      = tx;
        done_nxt    = 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (in_valid) begin
                    state_nxt   = ST_START;
                    shift_nxt   = in_data;
                    bit_idx_nxt = '0;
                    baud_nxt    = '0;
                    tx_nxt      = 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
                    par_nxt     = ^in_data;
`endif
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = ST_DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_nxt    = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef COUNT_UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
                        tx_nxt    = par;
`else
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        tx_nxt = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
`ifdef COUNT_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule
